// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// fifo_pkg : shared lane/width defaults and drain FSM encoding
// Rev 1.0
//==============================================================================
package fifo_pkg;

    localparam int DEF_N_DTPS     = 4;
    localparam int DEF_FIFO_WIDTH = 16;

    // Lane index width; N_DTPS is at least 2, so this is never zero.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// rr_arbiter : combinational round-robin pick of the lowest request at/after base
// Rev 1.0
//==============================================================================
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_DTPS = DEF_N_DTPS
) (
    input  logic [N_DTPS-1:0]         req_i,
    input  logic [lane_w(N_DTPS)-1:0] base_i,
    output logic                      gnt_valid_o,
    output logic [lane_w(N_DTPS)-1:0] gnt_idx_o
);

    localparam int LANE_W = lane_w(N_DTPS);

    // Descending scans so the lowest matching index is written last; the
    // second scan overrides the wrap-around pick only when a lane >= base hits.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int i = N_DTPS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = LANE_W'(i);
            end
        end
        for (int i = N_DTPS - 1; i >= 0; i--) begin
            if (req_i[i] && (i >= int'(base_i))) begin
                gnt_idx_o = LANE_W'(i);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_rr_drain.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// fifo_rr_drain : round-robin drain of a FIFO bank into one valid/ready stream
// Rev 1.0
//==============================================================================
module fifo_rr_drain
    import fifo_pkg::*;
#(
    parameter int N_DTPS     = DEF_N_DTPS,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_DTPS*FIFO_WIDTH-1:0] in_fifo,
    input  logic [N_DTPS-1:0]            is_fifo_empty,
    output logic [N_DTPS-1:0]            i_pop,
    output logic [FIFO_WIDTH-1:0]        o_data,
    output logic [lane_w(N_DTPS)-1:0]    o_lane,
    output logic                         o_valid,
    input  logic                         i_ready
);

    localparam int                LANE_W    = lane_w(N_DTPS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_DTPS - 1);

    state_e                  state_q, state_d;
    logic [LANE_W-1:0]       ptr_q, ptr_d;
    logic [LANE_W-1:0]       sel_q, sel_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;

    logic [LANE_W-1:0]       ptr_adv;
    logic [LANE_W-1:0]       arb_base;
    logic [LANE_W-1:0]       gnt_idx;
    logic                    gnt_valid;
    logic                    handshake;
    logic [N_DTPS-1:0]       pop;
    logic [FIFO_WIDTH-1:0]   lane_data [N_DTPS];

    for (genvar k = 0; k < N_DTPS; k++) begin : g_unpack
        assign lane_data[k] = in_fifo[k*FIFO_WIDTH +: FIFO_WIDTH];
    end

    assign handshake = valid_q && i_ready;
    assign ptr_adv   = (sel_q == LAST_LANE) ? '0 : sel_q + LANE_W'(1);
    // In HOLD the only pop opportunity is the handshake cycle, which arbitrates
    // from the pointer as it will be after this transfer retires.
    assign arb_base  = (state_q == HOLD) ? ptr_adv : ptr_q;

    rr_arbiter #(
        .N_DTPS (N_DTPS)
    ) u_arb (
        .req_i       (~is_fifo_empty),
        .base_i      (arb_base),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        lane_d  = lane_q;
        data_d  = data_q;
        valid_d = valid_q;
        pop     = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    pop[gnt_idx] = 1'b1;
                    sel_d        = gnt_idx;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                data_d  = lane_data[sel_q];
                lane_d  = sel_q;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    ptr_d   = ptr_adv;
                    valid_d = 1'b0;
                    if (gnt_valid) begin
                        pop[gnt_idx] = 1'b1;
                        sel_d        = gnt_idx;
                        state_d      = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop is combinational from state, so it is masked while reset is held.
    assign i_pop   = rst ? '0 : pop;
    assign o_data  = data_q;
    assign o_lane  = lane_q;
    assign o_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule : fifo_rr_drain
`default_nettype wire

// File: tb/tb_fifo_rr_drain.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_fifo_rr_drain : bank model + transaction-level round-robin reference
// Rev 1.0
//==============================================================================
module tb_fifo_rr_drain;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_fifo;
    logic [N-1:0]   is_fifo_empty;
    logic [N-1:0]   i_pop;
    logic [W-1:0]   o_data;
    logic [1:0]     o_lane;
    logic           o_valid;
    logic           i_ready;

    always #5 clk = ~clk;

    fifo_rr_drain #(
        .N_DTPS     (N),
        .FIFO_WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_fifo       (in_fifo),
        .is_fifo_empty (is_fifo_empty),
        .i_pop         (i_pop),
        .o_data        (o_data),
        .o_lane        (o_lane),
        .o_valid       (o_valid),
        .i_ready       (i_ready)
    );

    logic [W-1:0] bank [N][$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int           m_ptr;
    bit           m_wait;
    bit           m_valid;
    int           m_lane;
    logic [W-1:0] m_data;

    logic [N-1:0] s_pop;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic [1:0]   s_lane;

    int           acc_lane [$];
    logic [W-1:0] acc_data [$];
    int           acc_cyc  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic refresh_empty();
        for (int k = 0; k < N; k++) is_fifo_empty[k] = (bank[k].size() == 0);
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        bank[k].push_back(d);
        refresh_empty();
    endtask

    // Read data appears only in the cycle after a pop; other cycles carry junk.
    task automatic bank_step(input logic [N-1:0] pl);
        for (int k = 0; k < N; k++) begin
            in_fifo[k*W +: W] = 16'hDE00 + 16'(k);
            if (pl[k] && bank[k].size() > 0) in_fifo[k*W +: W] = bank[k].pop_front();
        end
        refresh_empty();
    endtask

    // First non-empty lane scanning cyclically from b.
    function automatic int pick(input int b);
        for (int j = 0; j < N; j++) begin
            if (bank[(b + j) % N].size() > 0) return (b + j) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        logic [N-1:0] pl;
        logic [N-1:0] ep;
        int           b;
        int           g;
        bit           acc;
        bit           free;
        @(negedge clk);
        cyc++;
        s_pop   = i_pop;
        s_valid = o_valid;
        s_data  = o_data;
        s_lane  = o_lane;
        if (rst) begin
            chk("rst_pop", 32'(i_pop), 32'd0);
            chk("rst_valid", 32'(o_valid), 32'd0);
            m_ptr   = 0;
            m_wait  = 1'b0;
            m_valid = 1'b0;
        end else begin
            chk("valid", 32'(o_valid), 32'(m_valid));
            if (m_valid) begin
                chk("data", 32'(o_data), 32'(m_data));
                chk("lane", 32'(o_lane), 32'(m_lane));
            end
            acc  = m_valid && i_ready;
            free = !(m_wait || m_valid) || acc;
            b    = acc ? (m_lane + 1) % N : m_ptr;
            g    = free ? pick(b) : -1;
            ep   = '0;
            if (g >= 0) ep[g] = 1'b1;
            chk("pop", 32'(i_pop), 32'(ep));
            if (o_valid && i_ready) begin
                acc_lane.push_back(int'(o_lane));
                acc_data.push_back(o_data);
                acc_cyc.push_back(cyc);
            end
            if (acc) begin
                m_ptr   = b;
                m_valid = 1'b0;
            end else if (m_wait) begin
                m_wait  = 1'b0;
                m_valid = 1'b1;
            end
            if (g >= 0) begin
                m_wait = 1'b1;
                m_lane = g;
                m_data = bank[g][0];
            end
        end
        pl = i_pop;
        @(posedge clk);
        #1;
        bank_step(pl);
    endtask

    task automatic drain(input int n, input int max_cyc);
        int start;
        int c;
        start = acc_lane.size();
        c     = 0;
        while ((acc_lane.size() - start) < n && c < max_cyc) begin
            tick();
            c++;
        end
        chk("drain_count", 32'(acc_lane.size() - start), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        rst     = 1'b1;
        i_ready = 1'b0;
        for (int k = 0; k < N; k++) in_fifo[k*W +: W] = 16'hDE00 + 16'(k);
        refresh_empty();

        // Reset, then idle with every lane empty
        repeat (3) tick();
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_lane", 32'(o_lane), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("idle_valid", 32'(s_valid), 32'd0);
        chk("idle_pop", 32'(s_pop), 32'd0);

        // Round-robin fairness: two words per lane
        i_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            push(k, 16'h1000 + 16'(k));
            push(k, 16'h1100 + 16'(k));
        end
        base = acc_lane.size();
        drain(8, 40);
        for (int i = 0; i < 8; i++) begin
            if (base + i < acc_lane.size()) begin
                chk("rr_lane", 32'(acc_lane[base+i]), 32'(i % 4));
                chk("rr_data", 32'(acc_data[base+i]), 32'((i < 4 ? 16'h1000 : 16'h1100) + 16'(i % 4)));
                if (i > 0) chk("rr_gap", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'd2);
            end
        end

        // Single lane: pop, wait, present
        push(2, 16'hA5A5);
        tick(); chk("single_pop", 32'(s_pop), 32'b0100);
        tick(); chk("single_wait_valid", 32'(s_valid), 32'd0);
        tick();
        chk("single_valid", 32'(s_valid), 32'd1);
        chk("single_data", 32'(s_data), 32'hA5A5);
        chk("single_lane", 32'(s_lane), 32'd2);
        tick(); chk("single_after_pop", 32'(s_pop), 32'd0);

        // Wrap from ptr=3 to lane 0, leaving ptr=1
        push(0, 16'h0B0B);
        tick(); chk("wrap_pop", 32'(s_pop), 32'b0001);
        repeat (3) tick();
        push(0, 16'h0C0C);
        push(1, 16'h0D0D);
        base = acc_lane.size();
        drain(2, 20);
        if (acc_lane.size() >= base + 2) begin
            chk("ptr1_first", 32'(acc_lane[base]), 32'd1);
            chk("ptr1_second", 32'(acc_lane[base+1]), 32'd0);
        end
        push(2, 16'h0E0E);
        drain(1, 10);
        push(3, 16'h0F03);
        push(0, 16'h0F00);
        base = acc_lane.size();
        drain(2, 20);
        if (acc_lane.size() >= base + 2) begin
            chk("skip_first_lane", 32'(acc_lane[base]), 32'd3);
            chk("skip_first_data", 32'(acc_data[base]), 32'h0F03);
            chk("skip_second_lane", 32'(acc_lane[base+1]), 32'd0);
        end

        // Backpressure: output held, no pop until the handshake cycle
        i_ready = 1'b0;
        push(1, 16'h00FF);
        c = 0;
        do begin
            tick();
            c++;
        end while (!s_valid && c < 10);
        chk("bp_valid_seen", 32'(s_valid), 32'd1);
        push(2, 16'h2222);
        repeat (5) begin
            tick();
            chk("bp_valid", 32'(s_valid), 32'd1);
            chk("bp_data", 32'(s_data), 32'h00FF);
            chk("bp_lane", 32'(s_lane), 32'd1);
            chk("bp_pop", 32'(s_pop), 32'd0);
        end
        i_ready = 1'b1;
        tick(); chk("bp_handshake_pop", 32'(s_pop), 32'b0100);
        base = acc_lane.size();
        drain(1, 10);
        if (acc_lane.size() > base) chk("bp_next_data", 32'(acc_data[base]), 32'h2222);

        // Reset while a popped word is in flight
        push(3, 16'h3333);
        push(1, 16'h1111);
        tick(); chk("mid_pop", 32'(s_pop), 32'b1000);
        rst = 1'b1;
        #1;
        chk("async_pop", 32'(i_pop), 32'd0);
        chk("async_valid", 32'(o_valid), 32'd0);
        chk("async_data", 32'(o_data), 32'd0);
        repeat (2) tick();
        rst  = 1'b0;
        base = acc_lane.size();
        drain(1, 10);
        if (acc_lane.size() > base) begin
            chk("post_rst_lane", 32'(acc_lane[base]), 32'd1);
            chk("post_rst_data", 32'(acc_data[base]), 32'h1111);
        end
        repeat (4) tick();
        chk("post_rst_idle", 32'(s_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fifo_rr_drain
`default_nettype wire

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Downstream consumer of the per-lane FIFO bank (N_DTPS lanes × FIFO_WIDTH bits).
- Selects one non-empty lane at a time, round-robin, and issues a one-cycle pop to it.
- Captures the word the bank returns one cycle later and presents it on a single valid/ready output stream, tagged with the lane index.
- Merges all data-path lanes into one serial stream for the next processing stage.

Parameters:
- N_DTPS, 4, number of FIFO lanes drained; must be ≥ 2.
- FIFO_WIDTH, 16, bits per FIFO word.
- LANE_W, $clog2(N_DTPS), width of the lane index; derived, not overridden.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_fifo  input  N_DTPS*FIFO_WIDTH  concatenated bank read data; lane k occupies bits [(k+1)*FIFO_WIDTH-1 : k*FIFO_WIDTH].
- is_fifo_empty  input  N_DTPS  per-lane empty flags from the bank.
- i_pop  output  N_DTPS  one-hot-or-zero pop request to the bank.
- o_data  output  FIFO_WIDTH  drained word.
- o_lane  output  LANE_W  source lane of o_data.
- o_valid  output  1  o_data/o_lane valid.
- i_ready  input  1  downstream accepts when o_valid && i_ready.

Behaviour:
- Clock and reset (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - i_pop = 0, o_valid = 0, o_data = 0, o_lane = 0.
  - RR pointer ptr = 0, state = IDLE.
  - Reset asserted mid-transfer discards the in-flight word; the bank word already popped is lost (accepted).
- Bank contract: read data for a lane popped in cycle t is valid on in_fifo in cycle t+1 only.
- Arbitration (combinational, from a base pointer B):
  - req = ~is_fifo_empty.
  - Grant the lowest-index set bit of req among lanes ≥ B.
  - If none, grant the lowest-index set bit of req overall.
  - If req = 0, no grant.
- FSM states IDLE, WAIT, HOLD:
  - IDLE, base B = ptr:
    - Grant g: drive i_pop[g] = 1 this cycle, latch sel = g, go to WAIT.
    - No grant: i_pop = 0, stay in IDLE.
  - WAIT:
    - i_pop = 0.
    - Capture o_data <= in_fifo lane sel, o_lane <= sel, o_valid <= 1, go to HOLD.
  - HOLD:
    - o_valid, o_data and o_lane stay stable until handshake.
    - No handshake (i_ready = 0): hold, i_pop = 0.
    - Handshake: ptr <= (sel == N_DTPS-1) ? 0 : sel+1. Then arbitrate in the same cycle with B = the new ptr value.
      - Grant g: i_pop[g] = 1, sel <= g, o_valid <= 0, go to WAIT.
      - No grant: o_valid <= 0, go to IDLE.
- Throughput: at most 1 word per 2 cycles. Latency from IDLE with a non-empty lane to o_valid is 2 cycles.
- is_fifo_empty is sampled only in cycles where a pop may be issued (IDLE, or HOLD with handshake).
- i_pop is never asserted for a lane whose empty flag is 1 in that cycle.
- At most one i_pop bit is set in any cycle.
- A push to a lane during WAIT or HOLD does not affect the current transfer.
- i_ready asserted while o_valid = 0 has no effect.

Decomposition:
- Shared package (fifo_pkg): FIFO_WIDTH and N_DTPS defaults, LANE_W derivation, and the FSM state enum (IDLE/WAIT/HOLD, 2-bit encoding).
- One sub-module, rr_arbiter: inputs req[N_DTPS] and base[LANE_W]; outputs gnt_valid and gnt_idx[LANE_W]. Purely combinational, reused by both pop-issue points.
- fifo_rr_drain holds the FSM, ptr, sel and the output register.

Test Plan:
- Reset then idle: rst = 1 for 3 cycles, all lanes empty for 10 cycles. Required: i_pop = 0 and o_valid = 0 throughout.
- Single lane: lane 2 holds 0xA5A5, i_ready = 1. Required: i_pop = 4'b0100 in cycle 1; cycle 3 shows o_valid = 1, o_data = 0xA5A5, o_lane = 2; ptr becomes 3.
- Round-robin fairness: all 4 lanes non-empty with words 0x1000+k, i_ready = 1. Required: o_lane sequence 0,1,2,3,0,...; one word every 2 cycles; exactly one i_pop bit per grant.
- Backpressure: lane 1 holds 0x00FF, i_ready = 0 for 5 cycles after o_valid, then 1. Required: o_data = 0x00FF and o_lane = 1 stable all 5 cycles; no further i_pop until the handshake cycle.
- Wrap and skip: ptr = 3, only lane 0 non-empty. Required: grant lane 0, then ptr = 1. Next, ptr = 3 with lanes 3 and 0 non-empty: required grant lane 3 first, then lane 0.
- Reset mid-operation: assert rst in WAIT. Required: o_valid = 0 and i_pop = 0 immediately (asynchronous); after release, ptr = 0 and arbitration restarts from lane 0.
